// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART FSM states, line levels and baud divisor helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with registered full/empty/level
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      level_nxt;
  logic             do_wr;
  logic             do_rd;

  // Full/empty are the registered flags, so a same-cycle pop never frees room for a write
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_comb begin
    level_nxt = level;
    if (do_wr && !do_rd) begin
      level_nxt = level + 1'b1;
    end else if (!do_wr && do_rd) begin
      level_nxt = level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_nxt;
      full  <= (level_nxt == (AW+1)'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_buffered_tx.sv
// rtl/uart_buffered_tx.sv - FIFO-buffered UART transmitter; define UART_TX_PARITY_EN for a parity bit
module uart_buffered_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic [7:0]                   Data_in,
  input  logic                         Wr_en,
  output logic                         Full,
  output logic                         Empty,
  output logic [$clog2(FIFO_DEPTH):0]  Level,
  output logic                         Overflow,
  output logic                         Busy,
  output logic                         Tx
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int CW       = $clog2(BAUD_DIV);

  uart_state_e   state;
  logic [CW-1:0] baud_cnt;
  logic [7:0]    shreg;
  logic [7:0]    fifo_dout;
  logic [2:0]    bit_idx;
  logic          stop_cnt;
  logic          tick;
  logic          stop_last;
  logic          pop;
`ifdef UART_TX_PARITY_EN
  logic          par_bit;
`endif

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .wr_en   (Wr_en),
    .wr_data (Data_in),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .full    (Full),
    .empty   (Empty),
    .level   (Level)
  );

  assign tick      = (baud_cnt == CW'(BAUD_DIV - 1));
  assign stop_last = (STOP_BITS == 1) || stop_cnt;
  // Popping at the final stop tick lets the next start bit follow with no idle gap
  assign pop       = !Empty && ((state == IDLE) || (state == STOP && tick && stop_last));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      Tx       <= LINE_IDLE;
      Busy     <= 1'b0;
      Overflow <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      Overflow <= Wr_en && Full;

      if (state == IDLE || tick) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      case (state)
        START: begin
          if (tick) begin
            state   <= DATA;
            Tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state    <= PARITY;
              Tx       <= par_bit;
`else
              state    <= STOP;
              Tx       <= LINE_STOP;
              stop_cnt <= 1'b0;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              Tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state    <= STOP;
            Tx       <= LINE_STOP;
            stop_cnt <= 1'b0;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (stop_last) begin
              state <= IDLE;
              Tx    <= LINE_IDLE;
              Busy  <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          Tx    <= LINE_IDLE;
          Busy  <= 1'b0;
        end
      endcase

      if (pop) begin
        state   <= START;
        Tx      <= LINE_START;
        Busy    <= 1'b1;
        shreg   <= fifo_dout;
`ifdef UART_TX_PARITY_EN
        par_bit <= (^fifo_dout) ^ PARITY_ODD;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_buffered_tx.sv
// tb/tb_uart_buffered_tx.sv - self-checking bench for uart_buffered_tx against a line-waveform model
module tb_uart_buffered_tx;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int HN = 16384;
  localparam int FL = (10 + P) * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr;
  logic       sel;
  logic [7:0] data;
  logic       wr1, wr2;
  logic       full1, empty1, ovf1, busy1, tx1;
  logic       full2, empty2, ovf2, busy2, tx2;
  logic [2:0] level1, level2;
  logic       tx_mon, busy_mon, full_mon, ovf_mon;

  assign wr1      = wr & ~sel;
  assign wr2      = wr & sel;
  assign tx_mon   = sel ? tx2 : tx1;
  assign busy_mon = sel ? busy2 : busy1;
  assign full_mon = sel ? full2 : full1;
  assign ovf_mon  = sel ? ovf2 : ovf1;

  uart_buffered_tx #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (4),
    .STOP_BITS  (1)
  ) u_dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .Data_in  (data),
    .Wr_en    (wr1),
    .Full     (full1),
    .Empty    (empty1),
    .Level    (level1),
    .Overflow (ovf1),
    .Busy     (busy1),
    .Tx       (tx1)
  );

  uart_buffered_tx #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (4),
    .STOP_BITS  (2)
  ) u_dut2 (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .Data_in  (data),
    .Wr_en    (wr2),
    .Full     (full2),
    .Empty    (empty2),
    .Level    (level2),
    .Overflow (ovf2),
    .Busy     (busy2),
    .Tx       (tx2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic tx_hist   [HN];
  logic busy_hist [HN];
  logic full_hist [HN];
  logic ovf_hist  [HN];

  always @(negedge clk) begin
    if (cyc < HN) begin
      tx_hist[cyc]   = tx_mon;
      busy_hist[cyc] = busy_mon;
      full_hist[cyc] = full_mon;
      ovf_hist[cyc]  = ovf_mon;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level of bit k of a frame carrying byte b
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (P == 1 && k == 9) return 1'(($countones(b)) % 2);
    return 1'b1;
  endfunction

  task automatic check_wave(input string tag, input int start, input logic [7:0] bq[$],
                            input int nstop, input int tail);
    int fc = (1 + 8 + P + nstop) * DIV;
    int total = fc * bq.size();
    int bad_tx = 0;
    int bad_busy = 0;
    logic et, eb;
    for (int i = start - 1; i < start + total + tail; i++) begin
      int rel = i - start;
      if (rel < 0 || rel >= total) begin
        et = 1'b1;
        eb = 1'b0;
      end else begin
        et = exp_bit(bq[rel / fc], (rel % fc) / DIV);
        eb = 1'b1;
      end
      if (tx_hist[i] !== et) bad_tx++;
      if (busy_hist[i] !== eb) bad_busy++;
    end
    chk({tag, " tx mismatching cycles"}, bad_tx, 0);
    chk({tag, " busy mismatching cycles"}, bad_busy, 0);
  endtask

  task automatic wait_until(input int idx);
    while (cyc < idx) @(negedge clk);
  endtask

  task automatic write_seq(input logic [7:0] bq[$], input int maxgap, output int first_edge);
    first_edge = cyc + 1;
    for (int i = 0; i < bq.size(); i++) begin
      data = bq[i];
      wr = 1'b1;
      @(negedge clk);
      if (i == 0) first_edge = cyc;
      wr = 1'b0;
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
  endtask

  logic [7:0] q[$];
  logic [7:0] none[$];
  logic [7:0] extra[6];
  int n, m, cnt;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr    = 1'b0;
    sel   = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset Tx", tx1, 1);
    chk("reset Busy", busy1, 0);
    chk("reset Full", full1, 0);
    chk("reset Empty", empty1, 1);
    chk("reset Level", level1, 0);
    chk("reset Overflow", ovf1, 0);
    chk("reset Tx dut2", tx2, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte with exact latency
    q = '{8'h55};
    data = 8'h55;
    wr = 1'b1;
    @(negedge clk);
    n = cyc;
    wr = 1'b0;
    chk("single Empty after write", empty1, 0);
    chk("single Level after write", level1, 1);
    chk("single Tx before start", tx1, 1);
    @(negedge clk);
    chk("single Tx start", tx1, 0);
    chk("single Busy start", busy1, 1);
    chk("single Empty after pop", empty1, 1);
    chk("single Level after pop", level1, 0);
    wait_until(n + 1 + FL + 5);
    check_wave("single", n + 1, q, 1, 3);
    cnt = 0;
    for (int i = n; i < n + FL + 5; i++) cnt += int'(busy_hist[i]);
    chk("single Busy cycles", cnt, FL);

    // Directed burst
    q = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    write_seq(q, 0, n);
    wait_until(n + 1 + 4 * FL + 5);
    check_wave("burst", n + 1, q, 1, 3);
    cnt = 0;
    for (int i = n + 1; i < n + 1 + 4 * FL; i++) cnt += int'(full_hist[i]);
    chk("burst Full cycles", cnt, 0);

    // Randomized bursts with random gaps
    for (int it = 0; it < 3; it++) begin
      q.delete();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) q.push_back(8'($urandom));
      write_seq(q, 2, n);
      wait_until(n + 1 + q.size() * FL + 5);
      check_wave("random burst", n + 1, q, 1, 3);
    end

    // Overflow: six writes into an empty FIFO while a frame is on the line
    q = '{8'($urandom)};
    data = q[0];
    wr = 1'b1;
    @(negedge clk);
    n = cyc;
    wr = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      extra[k] = 8'($urandom);
      if (k < 4) q.push_back(extra[k]);
    end
    for (int k = 0; k < 6; k++) begin
      data = extra[k];
      wr = 1'b1;
      @(negedge clk);
    end
    wr = 1'b0;
    chk("overflow Level", level1, 4);
    chk("overflow Full", full1, 1);
    wait_until(n + 1 + 5 * FL + 5);
    cnt = 0;
    for (int i = n; i < n + 30; i++) cnt += int'(ovf_hist[i]);
    chk("overflow pulse cycles", cnt, 2);
    check_wave("overflow", n + 1, q, 1, 3);

    // Reset during data bit 3 of 0x81 with two bytes queued
    q = '{8'h81, 8'($urandom), 8'($urandom)};
    write_seq(q, 0, n);
    wait_until(n + 1 + 4 * DIV + 4);
    chk("reset-mid Tx before reset", tx1, 0);
    rst_n = 1'b0;
    #1;
    chk("reset-mid Tx", tx1, 1);
    chk("reset-mid Level", level1, 0);
    chk("reset-mid Empty", empty1, 1);
    chk("reset-mid Busy", busy1, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m = cyc;
    wait_until(m + 260);
    check_wave("after reset", m + 2, none, 1, 250);
    chk("after reset Level", level1, 0);

    // Two stop bits
    sel = 1'b1;
    repeat (2) @(negedge clk);
    q = '{8'hC3, 8'($urandom)};
    write_seq(q, 0, n);
    wait_until(n + 1 + 2 * (FL + DIV) + 5);
    check_wave("two stop", n + 1, q, 2, 3);
    chk("two stop last stop cycle", tx_hist[n + 1 + (9 + P) * DIV + 19], 1);
    chk("two stop next start", tx_hist[n + 1 + (9 + P) * DIV + 20], 0);
    sel = 1'b0;
    repeat (2) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    q = '{8'h07, 8'h03};
    write_seq(q, 0, n);
    wait_until(n + 1 + 2 * FL + 5);
    check_wave("parity", n + 1, q, 1, 3);
    chk("parity bit 0x07", tx_hist[n + 1 + 9 * DIV + 5], 1);
    chk("parity bit 0x03", tx_hist[n + 1 + FL + 9 * DIV + 5], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_buffered_tx.md
# uart_buffered_tx

Buffered UART transmitter with its own baud-tick generator. It accepts bytes from on-chip logic through a write-enable FIFO interface and serialises them onto `Tx` as 8N1 frames, with optional parity. It runs directly on the 50 MHz system clock. It lets logic other than the receive path originate traffic on the serial line, such as status reports and command responses.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate. `BAUD_DIV = CLK_FREQ / BAUD`, truncated integer, must be ≥ 4.
- `FIFO_DEPTH`, default 16: byte entries; power of two, 2..256.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `Clk`, input, 1: system clock.
- `Rst_n`, input, 1: asynchronous, active-low reset.
- `Data_in`, input, 8: byte to queue.
- `Wr_en`, input, 1: write strobe, sampled on the rising edge of `Clk`.
- `Full`, output, 1: FIFO holds `FIFO_DEPTH` bytes.
- `Empty`, output, 1: FIFO holds 0 bytes.
- `Level`, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `Overflow`, output, 1: one-cycle pulse when a write is dropped.
- `Busy`, output, 1: a frame is on the line (state ≠ IDLE).
- `Tx`, output, 1: serial line, idle high.

## Operation
- Write acceptance:
  - A write is accepted iff `Wr_en`=1 and `Full`=0, using `Full` as registered at that edge.
  - A write while full is dropped, and `Overflow` pulses on the next cycle.
  - A pop in the same cycle does not free space for a write in that cycle.
- FSM states:
  - IDLE: `Tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `Tx`=0 for one bit time, then go to DATA.
  - DATA: 8 bits, LSB first, one bit time each. Bit index 0..7; after bit 7, go to PARITY (if enabled) or STOP.
  - PARITY: one bit time, then go to STOP.
  - STOP: `Tx`=1 for `STOP_BITS` bit times. At the end, if the FIFO is non-empty, pop and go directly to START with no extra idle cycle; otherwise go to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and produces a bit-end tick at BAUD_DIV-1.
  - Held at 0 in IDLE and restarted on entry to START, so bit times are exactly BAUD_DIV cycles.
- Simultaneous write and pop:
  - `Level` is unchanged.
  - If the FIFO was empty, the written byte is not popped that cycle. It is popped next cycle, or at the next STOP end.
- Reset:
  - Asserted mid-frame, `Tx` goes to 1 immediately (asynchronously), the FIFO is flushed and the FSM returns to IDLE.
  - The partially sent frame is abandoned and is not resent.

## Timing
- Reset values: `Tx`=1, `Busy`=0, `Full`=0, `Empty`=1, `Level`=0, `Overflow`=0.
- All outputs are registered.
- Latency with an empty FIFO and IDLE:
  - `Wr_en` sampled at edge N.
  - `Empty` falls at N+1; the FSM pops at N+1.
  - `Tx` falls and `Busy` rises at N+2.
- Frame length is (1+8+P+STOP_BITS)·BAUD_DIV cycles, where P is 1 with parity and 0 without.
- Back-to-back frames leave no gap: the start bit begins on the cycle after the last stop-bit cycle.
- `Level` and `Full`/`Empty` update on the cycle after the write or pop.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - Parameter `PARITY_ODD` (default 0) selects even (0) or odd (1) parity over the 8 data bits.
- Undefined:
  - No PARITY state and no `PARITY_ODD` parameter.
  - The frame is 8N1 (or 8N2).

## Structure
- Shared package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - Constants for idle/start/stop line levels.
  - A function computing `BAUD_DIV` from `CLK_FREQ` and `BAUD`, reused by the receive side.
- Sub-module `uart_sync_fifo`:
  - Single-clock, parameterised width and depth; pointers one bit wider than the address.
  - Outputs full/empty/level.
  - Reused later for a buffered receiver.

## Test plan
Bench parameters: CLK_FREQ=1_000_000, BAUD=100_000 (BAUD_DIV=10), FIFO_DEPTH=4.
- Single byte: write 0x55 while idle → `Tx` falls 2 cycles later; line reads 0,1,0,1,0,1,0,1,0,1, each for 10 cycles; `Busy` drops after 100 cycles.
- Burst: write 0xA5, 0x3C, 0xFF, 0x00 on consecutive cycles → 4 frames with no gap, total 400 cycles of `Busy`; `Full` is never asserted after the first pop.
- Overflow: hold the FSM in a frame, then write 6 bytes → `Level` saturates at 4; `Overflow` pulses twice; only the first 4 bytes appear on the line.
- Parity (with `UART_TX_PARITY_EN`, PARITY_ODD=0): 0x07 → parity bit 1; 0x03 → parity bit 0; frame is 110 cycles.
- Reset mid-frame: deassert `Rst_n` during DATA bit 3 of 0x81 with 2 bytes queued → `Tx`=1 in the same cycle; `Level`=0; after release, no further frames.
- STOP_BITS=2: send 0xC3 → stop high for 20 cycles before the next queued start bit.
